// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

   localparam int DATA_BITS      = 8;
   localparam int BIT_CNT_W      = $clog2(DATA_BITS);
   localparam int DEF_DIV_WIDTH  = 16;
   localparam int DEF_FIFO_DEPTH = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   function automatic logic parity_of(input logic [DATA_BITS-1:0] d, input logic odd);
      return (^d) ^ odd;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous TX byte FIFO with registered full/empty/level and a sticky
// overflow flag raised whenever a write arrives while full.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter  int DEPTH = DEF_FIFO_DEPTH,
   parameter  int WIDTH = DATA_BITS,
   localparam int AW    = $clog2(DEPTH),
   localparam int LVL_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic             ovf_clr,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [LVL_W-1:0] level,
   output logic             overflow
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push;
   logic             pop;
   logic [LVL_W-1:0] level_nxt;

   // Full is judged on the pre-edge state, so a same-cycle pop never rescues a write.
   assign push    = wr_en && !full;
   assign pop     = rd_en && !empty;
   assign rd_data = mem[rd_ptr];

   always_comb begin
      level_nxt = level;
      if (push && !pop) begin
         level_nxt = level + LVL_W'(1);
      end else if (pop && !push) begin
         level_nxt = level - LVL_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         level <= level_nxt;
         full  <= (level_nxt == LVL_W'(DEPTH));
         empty <= (level_nxt == '0);
         // A drop in the same cycle as a clear keeps the flag set.
         if (wr_en && full) begin
            overflow <= 1'b1;
         end else if (ovf_clr) begin
            overflow <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: byte FIFO feeding an 8N1 / 8x1 serialiser with optional
// parity. Frame settings are latched at each pop and held for the whole frame.
module uart_tx_engine
   import uart_pkg::*;
#(
   parameter  int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter  int DIV_WIDTH  = DEF_DIV_WIDTH,
   localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                 S_AXI_ACLK,
   input  logic                 S_AXI_ARESETN,
   input  logic                 tx_wr_en,
   input  logic [7:0]           tx_wr_data,
   input  logic                 tx_en,
   input  logic [DIV_WIDTH-1:0] baud_div,
   input  logic                 parity_en,
   input  logic                 parity_odd,
   input  logic                 tx_ovf_clr,
   output logic                 tx_fifo_full,
   output logic                 tx_fifo_empty,
   output logic [LVL_W-1:0]     tx_fifo_level,
   output logic                 tx_busy,
   output logic                 tx_overflow,
   output logic                 uart_txd
);

   tx_state_t              state;
   logic [DIV_WIDTH-1:0]   div_lat;
   logic [DIV_WIDTH-1:0]   timer;
   logic [DATA_BITS-1:0]   shift;
   logic [DATA_BITS-1:0]   head;
   logic [BIT_CNT_W-1:0]   bit_cnt;
   logic                   par_en_lat;
   logic                   par_bit;
   logic                   bit_done;
   logic                   pop;

   assign bit_done = (timer == div_lat);
   // Pop either from idle or at the tail of a stop bit, giving gap-free frames.
   assign pop = tx_en && !tx_fifo_empty &&
                ((state == IDLE) || ((state == STOP) && bit_done));

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_BITS)
   ) u_fifo (
      .clk      (S_AXI_ACLK),
      .rst_n    (S_AXI_ARESETN),
      .wr_en    (tx_wr_en),
      .wr_data  (tx_wr_data),
      .rd_en    (pop),
      .ovf_clr  (tx_ovf_clr),
      .rd_data  (head),
      .full     (tx_fifo_full),
      .empty    (tx_fifo_empty),
      .level    (tx_fifo_level),
      .overflow (tx_overflow)
   );

   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         state    <= IDLE;
         uart_txd <= 1'b1;
         tx_busy  <= 1'b0;
         timer    <= '0;
         bit_cnt  <= '0;
      end else if (pop) begin
         shift      <= head;
         par_bit    <= parity_of(head, parity_odd);
         div_lat    <= baud_div;
         par_en_lat <= parity_en;
         state      <= START;
         uart_txd   <= 1'b0;
         tx_busy    <= 1'b1;
         timer      <= '0;
      end else if (state != IDLE) begin
         if (!bit_done) begin
            timer <= timer + DIV_WIDTH'(1);
         end else begin
            timer <= '0;
            case (state)
               START: begin
                  state    <= DATA;
                  uart_txd <= shift[0];
                  bit_cnt  <= '0;
               end
               DATA: begin
                  if (bit_cnt == BIT_CNT_W'(DATA_BITS - 1)) begin
                     if (par_en_lat) begin
                        state    <= PARITY;
                        uart_txd <= par_bit;
                     end else begin
                        state    <= STOP;
                        uart_txd <= 1'b1;
                     end
                  end else begin
                     bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
                     shift    <= {1'b0, shift[DATA_BITS-1:1]};
                     uart_txd <= shift[1];
                  end
               end
               PARITY: begin
                  state    <= STOP;
                  uart_txd <= 1'b1;
               end
               STOP: begin
                  state    <= IDLE;
                  uart_txd <= 1'b1;
                  tx_busy  <= 1'b0;
               end
               default: begin
                  state    <= IDLE;
                  uart_txd <= 1'b1;
                  tx_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Randomised self-checking bench for uart_tx_engine against a queue-based
// frame model built from the byte stream and the frame format rules.
module tb_uart_tx_engine;

   logic        clk = 1'b0;
   logic        rstn;
   logic        tx_wr_en;
   logic [7:0]  tx_wr_data;
   logic        tx_en;
   logic [15:0] baud_div;
   logic        parity_en;
   logic        parity_odd;
   logic        tx_ovf_clr;
   logic        tx_fifo_full;
   logic        tx_fifo_empty;
   logic [3:0]  tx_fifo_level;
   logic        tx_busy;
   logic        tx_overflow;
   logic        uart_txd;

   int errors = 0;
   int checks = 0;
   logic [7:0] exp_q[$];
   logic [3:0] stream_lvl0;
   logic       stream_ovf0;

   uart_tx_engine #(.FIFO_DEPTH(8), .DIV_WIDTH(16)) dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESETN (rstn),
      .tx_wr_en      (tx_wr_en),
      .tx_wr_data    (tx_wr_data),
      .tx_en         (tx_en),
      .baud_div      (baud_div),
      .parity_en     (parity_en),
      .parity_odd    (parity_odd),
      .tx_ovf_clr    (tx_ovf_clr),
      .tx_fifo_full  (tx_fifo_full),
      .tx_fifo_empty (tx_fifo_empty),
      .tx_fifo_level (tx_fifo_level),
      .tx_busy       (tx_busy),
      .tx_overflow   (tx_overflow),
      .uart_txd      (uart_txd)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_byte(input logic [7:0] b);
      tx_wr_en   = 1'b1;
      tx_wr_data = b;
      tick();
      tx_wr_en   = 1'b0;
   endtask

   // The next edge must be the one that pops the first queued byte.
   task automatic check_stream(input string tag, input int div, input bit pe,
                               input bit po, input bit scramble);
      int bad_txd = 0;
      int bad_busy = 0;
      bit first = 1'b1;
      bit bits [0:10];
      int nb;
      logic [7:0] b;
      while (exp_q.size() > 0) begin
         b = exp_q.pop_front();
         bits[0] = 1'b0;
         for (int i = 0; i < 8; i++) bits[1+i] = b[i];
         nb = 9;
         if (pe) begin
            bits[9] = 1'(($countones(b) % 2)) ^ po;
            nb = 10;
         end
         bits[nb] = 1'b1;
         nb++;
         for (int j = 0; j < nb; j++) begin
            for (int r = 0; r <= div; r++) begin
               tick();
               if (first) begin
                  stream_lvl0 = tx_fifo_level;
                  stream_ovf0 = tx_overflow;
                  tx_wr_en    = 1'b0;
                  if (scramble) begin
                     baud_div   = 16'($urandom_range(0, 9));
                     parity_en  = ~parity_en;
                     parity_odd = ~parity_odd;
                     tx_en      = 1'b0;
                  end
                  first = 1'b0;
               end
               if (uart_txd !== bits[j]) bad_txd++;
               if (tx_busy !== 1'b1) bad_busy++;
            end
         end
      end
      chk({tag, "_txd_bits"}, bad_txd, 0);
      chk({tag, "_busy_held"}, bad_busy, 0);
      tick();
      chk({tag, "_end_txd"}, uart_txd, 1);
      chk({tag, "_end_busy"}, tx_busy, 0);
      chk({tag, "_end_level"}, tx_fifo_level, 0);
   endtask

   task automatic single(input string tag, input logic [7:0] b, input int div,
                         input bit pe, input bit po, input bit scramble);
      baud_div   = 16'(div);
      parity_en  = pe;
      parity_odd = po;
      tx_en      = 1'b1;
      write_byte(b);
      chk({tag, "_empty_after_wr"}, tx_fifo_empty, 0);
      exp_q.push_back(b);
      check_stream(tag, div, pe, po, scramble);
   endtask

   initial begin
      int n;
      int div;
      bit pe, po;
      int bad;
      rstn = 1'b0; tx_wr_en = 1'b0; tx_wr_data = '0; tx_en = 1'b0;
      baud_div = 16'd3; parity_en = 1'b0; parity_odd = 1'b0; tx_ovf_clr = 1'b0;
      repeat (3) tick();
      chk("rst_txd", uart_txd, 1);
      chk("rst_busy", tx_busy, 0);
      chk("rst_empty", tx_fifo_empty, 1);
      chk("rst_full", tx_fifo_full, 0);
      chk("rst_level", tx_fifo_level, 0);
      chk("rst_ovf", tx_overflow, 0);
      rstn = 1'b1;
      tick();

      single("basic_a5", 8'hA5, 3, 1'b0, 1'b0, 1'b0);
      single("par_even_a5", 8'hA5, 3, 1'b1, 1'b0, 1'b0);
      single("par_odd_a5", 8'hA5, 3, 1'b1, 1'b1, 1'b0);
      single("par_even_07", 8'h07, 2, 1'b1, 1'b0, 1'b0);

      for (int k = 0; k < 6; k++) begin
         single("rnd_single", 8'($urandom), $urandom_range(0, 4),
                1'($urandom), 1'($urandom), 1'b1);
      end

      // Overflow: fill with transmitter disabled.
      tx_en = 1'b0; baud_div = 16'd1; parity_en = 1'b0; parity_odd = 1'b0;
      for (int k = 1; k <= 8; k++) write_byte(8'(k));
      chk("ovf_full8", tx_fifo_full, 1);
      chk("ovf_level8", tx_fifo_level, 8);
      chk("ovf_not_yet", tx_overflow, 0);
      write_byte(8'h09);
      chk("ovf_set", tx_overflow, 1);
      chk("ovf_level_hold", tx_fifo_level, 8);
      tx_ovf_clr = 1'b1; tick(); tx_ovf_clr = 1'b0;
      chk("ovf_cleared", tx_overflow, 0);
      tx_ovf_clr = 1'b1; write_byte(8'h0B); tx_ovf_clr = 1'b0;
      chk("ovf_set_beats_clr", tx_overflow, 1);
      tx_ovf_clr = 1'b1; tick(); tx_ovf_clr = 1'b0;
      chk("ovf_cleared2", tx_overflow, 0);
      for (int k = 1; k <= 8; k++) exp_q.push_back(8'(k));
      tx_en = 1'b1; tx_wr_en = 1'b1; tx_wr_data = 8'h0A;
      check_stream("ovf_drain", 1, 1'b0, 1'b0, 1'b0);
      chk("ovf_pop_level", stream_lvl0, 7);
      chk("ovf_drop_with_pop", stream_ovf0, 1);

      // Back-to-back at one clock per bit.
      baud_div = 16'd0; tx_en = 1'b1;
      write_byte(8'h00);
      tx_wr_en = 1'b1; tx_wr_data = 8'hFF;
      exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
      check_stream("b2b", 0, 1'b0, 1'b0, 1'b0);
      chk("b2b_level_after_pop", stream_lvl0, 1);

      // Write coinciding with the idle pop.
      tx_en = 1'b0; baud_div = 16'd1;
      write_byte(8'h3C);
      chk("sim_level1", tx_fifo_level, 1);
      tx_en = 1'b1; tx_wr_en = 1'b1; tx_wr_data = 8'hC3;
      exp_q.push_back(8'h3C); exp_q.push_back(8'hC3);
      check_stream("sim_wr_pop", 1, 1'b0, 1'b0, 1'b0);
      chk("sim_level_kept", stream_lvl0, 1);

      for (int k = 0; k < 4; k++) begin
         tx_en = 1'b0;
         n = $urandom_range(1, 5);
         div = $urandom_range(0, 3);
         pe = 1'($urandom); po = 1'($urandom);
         baud_div = 16'(div); parity_en = pe; parity_odd = po;
         for (int i = 0; i < n; i++) begin
            tx_wr_data = 8'($urandom);
            exp_q.push_back(tx_wr_data);
            write_byte(tx_wr_data);
         end
         chk("burst_level", tx_fifo_level, 32'(exp_q.size()));
         tx_en = 1'b1;
         check_stream("burst", div, pe, po, 1'b0);
      end

      // Reset during DATA with bytes still queued.
      tx_en = 1'b0; baud_div = 16'd3; parity_en = 1'b0;
      write_byte(8'h5A); write_byte(8'h96); write_byte(8'hF0);
      tx_en = 1'b1;
      repeat (8) tick();
      chk("pre_rst_busy", tx_busy, 1);
      rstn = 1'b0;
      tick();
      chk("midrst_txd", uart_txd, 1);
      chk("midrst_busy", tx_busy, 0);
      chk("midrst_empty", tx_fifo_empty, 1);
      chk("midrst_level", tx_fifo_level, 0);
      rstn = 1'b1;
      bad = 0;
      repeat (60) begin
         tick();
         if (uart_txd !== 1'b1 || tx_busy !== 1'b0) bad++;
      end
      chk("post_rst_quiet", bad, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
